i2c_target_regfile: RTL and testbench



---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_bus_sync.sv | 43 ++++
 rtl/i2c_target_regfile.sv | 186 ++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, master command codes and ACK/NACK bus levels.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } i2c_tgt_state_t;

    typedef enum logic [1:0] {
        I2C_CMD_START,
        I2C_CMD_STOP,
        I2C_CMD_WRITE,
        I2C_CMD_READ
    } i2c_cmd_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes raw SCL/SDA into the clk domain and flags SCL edges and START/STOP conditions.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic r_scl_meta, r_scl_sync, r_scl_hist;
    logic r_sda_meta, r_sda_sync, r_sda_hist;

    // Idle bus is high, so the chain resets high to avoid phantom edges after reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_hist <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_meta <= scl_i;
            r_scl_sync <= r_scl_meta;
            r_scl_hist <= r_scl_sync;
            r_sda_meta <= sda_i;
            r_sda_sync <= r_sda_meta;
            r_sda_hist <= r_sda_sync;
        end
    end

    assign scl_rise  =  r_scl_sync & ~r_scl_hist;
    assign scl_fall  = ~r_scl_sync &  r_scl_hist;
    assign start_det =  r_scl_sync &  r_scl_hist &  r_sda_hist & ~r_sda_sync;
    assign stop_det  =  r_scl_sync &  r_scl_hist & ~r_sda_hist &  r_sda_sync;
    assign sda_s     =  r_sda_sync;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target exposing NREGS 8-bit registers behind a pointer byte with auto-increment.
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR  = 7'h10,
    parameter int          NREGS = 32,
    localparam int         PW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          scl_oe,
    output logic          sda_oe,
    output logic          wr_stb,
    output logic [PW-1:0] wr_ptr,
    output logic [7:0]    wr_data,
    output logic          busy,
    input  logic [PW-1:0] local_addr,
    output logic [7:0]    local_data
);

    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_s;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start),
        .stop_det  (w_stop),
        .sda_s     (w_sda_s)
    );

    i2c_tgt_state_t r_state;
    logic [7:0]     r_regs [NREGS];
    logic [7:0]     r_shift;
    logic [2:0]     r_bit_cnt;
    logic           r_byte_done;
    logic           r_rw;
    logic [PW-1:0]  r_ptr;
    logic           r_sda_oe;
    logic           r_busy;
    logic           r_wr_stb;
    logic [PW-1:0]  r_wr_ptr;
    logic [7:0]     r_wr_data;
    logic [7:0]     r_local_data;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(NREGS - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_byte_done <= 1'b0;
            r_rw        <= 1'b0;
            r_ptr       <= '0;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_stb    <= 1'b0;
            r_wr_ptr    <= '0;
            r_wr_data   <= '0;
            // NOTE: the register file is cleared by reset, so it must live in flops rather than RAM.
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            r_wr_stb <= 1'b0;
            if (w_start) begin
                r_state     <= ST_ADDR;
                r_bit_cnt   <= '0;
                r_byte_done <= 1'b0;
                r_sda_oe    <= 1'b0;
            end else if (w_stop) begin
                r_state     <= ST_IDLE;
                r_bit_cnt   <= '0;
                r_byte_done <= 1'b0;
                r_sda_oe    <= 1'b0;
                r_busy      <= 1'b0;
            end else if (w_scl_rise) begin
                case (r_state)
                    ST_ADDR, ST_PTR, ST_WDATA: begin
                        r_shift     <= {r_shift[6:0], w_sda_s};
                        r_bit_cnt   <= r_bit_cnt + 3'd1;
                        r_byte_done <= (r_bit_cnt == 3'd7);
                    end
                    ST_RDATA: begin
                        r_bit_cnt   <= r_bit_cnt + 3'd1;
                        r_byte_done <= (r_bit_cnt == 3'd7);
                    end
                    ST_RDATA_ACK: begin
                        r_ptr <= ptr_next(r_ptr);
                        if (w_sda_s == I2C_NACK) r_state <= ST_IDLE;
                    end
                    default: ;
                endcase
            end else if (w_scl_fall) begin
                case (r_state)
                    ST_ADDR: if (r_byte_done) begin
                        r_byte_done <= 1'b0;
                        if (r_shift[7:1] == ADDR) begin
                            r_rw     <= r_shift[0];
                            r_busy   <= 1'b1;
                            r_sda_oe <= 1'b1;
                            r_state  <= ST_ADDR_ACK;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_ADDR_ACK: begin
                        r_bit_cnt <= '0;
                        if (r_rw) begin
                            r_shift  <= r_regs[r_ptr];
                            r_sda_oe <= ~r_regs[r_ptr][7];
                            r_state  <= ST_RDATA;
                        end else begin
                            r_sda_oe <= 1'b0;
                            r_state  <= ST_PTR;
                        end
                    end
                    ST_PTR: if (r_byte_done) begin
                        r_byte_done <= 1'b0;
                        if ({24'd0, r_shift} < 32'(NREGS)) begin
                            r_ptr    <= r_shift[PW-1:0];
                            r_sda_oe <= 1'b1;
                            r_state  <= ST_PTR_ACK;
                        end else begin
                            r_state  <= ST_IDLE;
                        end
                    end
                    ST_PTR_ACK, ST_WDATA_ACK: begin
                        r_sda_oe <= 1'b0;
                        r_state  <= ST_WDATA;
                    end
                    ST_WDATA: if (r_byte_done) begin
                        r_byte_done   <= 1'b0;
                        r_regs[r_ptr] <= r_shift;
                        r_wr_stb      <= 1'b1;
                        r_wr_ptr      <= r_ptr;
                        r_wr_data     <= r_shift;
                        r_ptr         <= ptr_next(r_ptr);
                        r_sda_oe      <= 1'b1;
                        r_state       <= ST_WDATA_ACK;
                    end
                    ST_RDATA: begin
                        if (r_byte_done) begin
                            r_byte_done <= 1'b0;
                            r_sda_oe    <= 1'b0;
                            r_state     <= ST_RDATA_ACK;
                        end else begin
                            r_shift  <= {r_shift[6:0], 1'b0};
                            r_sda_oe <= ~r_shift[6];
                        end
                    end
                    // Still here on the fall means the master ACKed; r_ptr already advanced.
                    ST_RDATA_ACK: begin
                        r_bit_cnt <= '0;
                        r_shift   <= r_regs[r_ptr];
                        r_sda_oe  <= ~r_regs[r_ptr][7];
                        r_state   <= ST_RDATA;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Reads the pre-write value when the bus writes the same index this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_local_data <= '0;
        else        r_local_data <= r_regs[local_addr];
    end

    assign scl_oe     = 1'b0;
    assign sda_oe     = r_sda_oe;
    assign wr_stb     = r_wr_stb;
    assign wr_ptr     = r_wr_ptr;
    assign wr_data    = r_wr_data;
    assign busy       = r_busy;
    assign local_data = r_local_data;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: table of write transactions plus read/abort/reset sequences.
module tb_i2c_target_regfile;
    import i2c_pkg::*;

    localparam int NREGS = 32;
    localparam int PW    = 5;
    localparam int Q     = 80;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m_scl = 1'b1;
    logic          m_sda = 1'b1;
    logic          scl_i, sda_i;
    logic          scl_oe, sda_oe, wr_stb, busy;
    logic [PW-1:0] wr_ptr;
    logic [7:0]    wr_data;
    logic [PW-1:0] local_addr = '0;
    logic [7:0]    local_data;

    assign scl_i = m_scl;
    assign sda_i = m_sda & ~sda_oe;

    i2c_target_regfile #(.ADDR(7'h10), .NREGS(NREGS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .scl_oe     (scl_oe),
        .sda_oe     (sda_oe),
        .wr_stb     (wr_stb),
        .wr_ptr     (wr_ptr),
        .wr_data    (wr_data),
        .busy       (busy),
        .local_addr (local_addr),
        .local_data (local_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic [12:0] stb_q[$];
    logic        saw_oe, saw_busy;

    always @(negedge clk) begin
        if (wr_stb) stb_q.push_back({wr_ptr, wr_data});
        if (sda_oe) saw_oe = 1'b1;
        if (busy)   saw_busy = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic bus_start();
        m_sda = 1'b1; #Q;
        m_scl = 1'b1; #Q;
        m_sda = 1'b0; #Q;
        m_scl = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; #Q;
        m_scl = 1'b1; #Q;
        m_sda = 1'b1; #Q;
    endtask

    task automatic bus_bit(input logic b, output logic s);
        m_sda = b;    #Q;
        m_scl = 1'b1; #Q;
        s = sda_i;    #Q;
        m_scl = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(1'b1, d[i]);
        bus_bit(ack, s);
    endtask

    task automatic local_read(input logic [PW-1:0] idx, output logic [7:0] d);
        @(negedge clk);
        local_addr = idx;
        @(negedge clk);
        d = local_data;
    endtask

    typedef struct {
        logic [7:0] addr_b;
        logic [7:0] ptr_b;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [3:0] exp_ack;   // {addr, ptr, d0, d1}, 0 = ACK
        logic       exp_busy;
        int         exp_nstb;
    } wvec_t;

    wvec_t      vecs[6];
    logic [7:0] model[NREGS];

    initial begin
        logic [3:0]    acks;
        logic          a;
        logic [7:0]    d;
        logic [7:0]    dv[2];
        logic [PW-1:0] p;

        vecs[0] = '{8'h20, 8'h03, 8'hAA, 8'h55, 4'b0000, 1'b1, 2};
        vecs[1] = '{8'h22, 8'h03, 8'h11, 8'h22, 4'b1111, 1'b0, 0};
        vecs[2] = '{8'h20, 8'h20, 8'h66, 8'h77, 4'b0111, 1'b1, 0};
        vecs[3] = '{8'h20, 8'h1F, 8'h5A, 8'hC3, 4'b0000, 1'b1, 2};
        vecs[4] = '{8'h00, 8'h03, 8'h99, 8'h88, 4'b1111, 1'b0, 0};
        vecs[5] = '{8'h20, 8'h10, 8'h01, 8'hFE, 4'b0000, 1'b1, 2};
        for (int i = 0; i < NREGS; i++) model[i] = 8'h00;

        #25;
        check("reset sda_oe", sda_oe, 0);
        check("reset scl_oe", scl_oe, 0);
        check("reset wr_stb", wr_stb, 0);
        check("reset busy", busy, 0);
        check("reset wr_ptr", wr_ptr, 0);
        check("reset wr_data", wr_data, 0);
        check("reset local_data", local_data, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            stb_q.delete();
            saw_oe = 1'b0;
            saw_busy = 1'b0;
            dv[0] = vecs[v].d0;
            dv[1] = vecs[v].d1;
            bus_start();
            send_byte(vecs[v].addr_b, acks[3]);
            send_byte(vecs[v].ptr_b, acks[2]);
            send_byte(vecs[v].d0, acks[1]);
            send_byte(vecs[v].d1, acks[0]);
            bus_stop();
            repeat (4) @(negedge clk);
            check($sformatf("v%0d acks", v), acks, vecs[v].exp_ack);
            check($sformatf("v%0d busy seen", v), saw_busy, vecs[v].exp_busy);
            check($sformatf("v%0d busy after stop", v), busy, 0);
            check($sformatf("v%0d sda_oe seen", v), saw_oe, (vecs[v].exp_ack != 4'b1111));
            check($sformatf("v%0d wr_stb count", v), stb_q.size(), vecs[v].exp_nstb);
            for (int i = 0; i < vecs[v].exp_nstb; i++) begin
                p = PW'((int'(vecs[v].ptr_b) + i) % NREGS);
                model[p] = dv[i];
                if (i < stb_q.size())
                    check($sformatf("v%0d stb%0d", v, i), stb_q[i], {p, dv[i]});
            end
            for (int i = 0; i < 2; i++) begin
                p = PW'((int'(vecs[v].ptr_b[PW-1:0]) + i) % NREGS);
                local_read(p, d);
                check($sformatf("v%0d reg[%0d]", v, p), d, model[p]);
            end
            local_read(PW'(3), d);
            check($sformatf("v%0d reg[3]", v), d, model[3]);
        end

        // Pointer 31 then repeated-START read: 0x5A, wrap to 0x00 -> 0xC3, then NACK.
        stb_q.delete();
        bus_start();
        send_byte(8'h20, a); check("rd addr W ack", a, I2C_ACK);
        send_byte(8'h1F, a); check("rd ptr ack", a, I2C_ACK);
        bus_start();
        send_byte(8'h21, a); check("rd addr R ack", a, I2C_ACK);
        recv_byte(I2C_ACK, d);  check("rd byte0", d, 8'h5A);
        recv_byte(I2C_NACK, d); check("rd byte1 wrap", d, 8'hC3);
        saw_oe = 1'b0;
        send_byte(8'h00, a);
        check("rd released after nack", saw_oe, 0);
        check("rd busy until stop", busy, 1);
        bus_stop();
        repeat (4) @(negedge clk);
        check("rd busy after stop", busy, 0);
        check("rd no wr_stb", stb_q.size(), 0);

        // STOP after 5 bits of a data byte, then a normal write.
        stb_q.delete();
        bus_start();
        send_byte(8'h20, a);
        send_byte(8'h05, a);
        for (int i = 7; i >= 3; i--) bus_bit(d[0] ^ (i[0]), a);
        bus_stop();
        repeat (4) @(negedge clk);
        check("abort no wr_stb", stb_q.size(), 0);
        check("abort busy", busy, 0);
        local_read(PW'(5), d);
        check("abort reg[5]", d, model[5]);
        bus_start();
        send_byte(8'h20, a); check("post-abort addr ack", a, I2C_ACK);
        send_byte(8'h05, a); check("post-abort ptr ack", a, I2C_ACK);
        send_byte(8'h77, a); check("post-abort data ack", a, I2C_ACK);
        bus_stop();
        repeat (4) @(negedge clk);
        model[5] = 8'h77;
        check("post-abort wr_stb count", stb_q.size(), 1);
        if (stb_q.size() > 0) check("post-abort stb", stb_q[0], {PW'(5), 8'h77});
        local_read(PW'(5), d);
        check("post-abort reg[5]", d, 8'h77);

        // Reset while the target is driving the address ACK.
        local_read(PW'(3), d);
        check("pre-reset reg[3]", d, model[3]);
        bus_start();
        for (int i = 7; i >= 0; i--) bus_bit(((8'h20 >> i) & 8'h01) != 0, a);
        check("ack driven before reset", sda_oe, 1);
        #3 rst_n = 1'b0;
        #1;
        check("reset releases sda_oe", sda_oe, 0);
        check("reset clears busy", busy, 0);
        m_scl = 1'b1;
        m_sda = 1'b1;
        #50;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("reg[3] cleared", local_data, 0);
        local_read(PW'(5), d);
        check("reg[5] cleared", d, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
